// File: rtl/waveforms_pkg.sv
// Shared types and constants for the SSD1306 waveform streamer: FSM states,
// register map, status bit positions and default column glyphs.
package waveforms_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLUMN,
        ST_SHIFT,
        ST_SEL_CMD,
        ST_DC_RESTORE
    } state_t;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_SPI    = 4'h1;
    localparam logic [3:0] ADDR_PRESC  = 4'h2;
    localparam logic [3:0] ADDR_CTRL   = 4'h3;
    localparam logic [3:0] ADDR_SEL    = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_PREV   = 4'h1;

    localparam int STAT_IDLE  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    localparam int CTRL_CS      = 0;
    localparam int CTRL_DC      = 1;
    localparam int CTRL_GND     = 2;
    localparam int CTRL_EDGE    = 3;
    localparam int CTRL_CLR_OVF = 4;

    localparam logic [7:0] DEF_HI_GLYPH   = 8'h02;
    localparam logic [7:0] DEF_LO_GLYPH   = 8'h40;
    localparam logic [7:0] DEF_EDGE_GLYPH = 8'h7E;
    localparam logic [7:0] SEL_OPCODE     = 8'hB0;

    // Lower seven column bits for one pixel; bit7 of the column is the gnd line.
    function automatic logic [6:0] column_bits(input logic       pix,
                                               input logic       prev,
                                               input logic       edge_en,
                                               input logic [6:0] hi,
                                               input logic [6:0] lo,
                                               input logic [6:0] edg);
        if (edge_en && (pix != prev)) return edg;
        else if (pix)                 return hi;
        else                          return lo;
    endfunction

endpackage

// File: rtl/waveforms_fifo.sv
// Pixel-byte FIFO, first-word-fall-through; a push on a full FIFO is taken
// only when a pop frees a slot in the same cycle.
module waveforms_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == FULL_LEVEL);
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/tqvp_waveforms_streamer.sv
// TinyQV peripheral: pixel bytes queued in a FIFO are expanded into SSD1306
// column glyphs and shifted out over SPI; raw bytes and page selects also supported.
module tqvp_waveforms_streamer
    import waveforms_pkg::*;
#(
    parameter int unsigned PRESC_W    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          CPOL       = 1'b0,
    parameter logic [7:0]  HI_GLYPH   = DEF_HI_GLYPH,
    parameter logic [7:0]  LO_GLYPH   = DEF_LO_GLYPH,
    parameter logic [7:0]  EDGE_GLYPH = DEF_EDGE_GLYPH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_t             state;
    state_t             cont;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] div_cnt;
    logic [3:0]         half_cnt;
    logic [3:0]         cnt_px;
    logic [7:0]         tx;
    logic [7:0]         bfr;
    logic sck, mosi, dc, gnd, edge_en, cs_reg, overflow, prev_bit;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_data;
    logic [LVL_W-1:0] fifo_level;

    logic wr_data, wr_spi, wr_presc, wr_ctrl, wr_sel;
    logic engine_idle, spi_go, sel_go, ovf_set, half_end, shift_next, cs_n;
    logic [6:0] glyph;
    logic [4:0] lvl_ext;
    logic [3:0] lvl_sat;
    logic       unused_ui;

    assign unused_ui = &{1'b0, ui_in};

    assign wr_data  = data_write && (address == ADDR_DATA);
    assign wr_spi   = data_write && (address == ADDR_SPI);
    assign wr_presc = data_write && (address == ADDR_PRESC);
    assign wr_ctrl  = data_write && (address == ADDR_CTRL);
    assign wr_sel   = data_write && (address == ADDR_SEL);

    assign engine_idle = (state == ST_IDLE) && fifo_empty;
    assign spi_go      = wr_spi && engine_idle;
    assign sel_go      = wr_sel && engine_idle;
    assign fifo_push   = wr_data;
    assign fifo_pop    = (state == ST_IDLE) && !fifo_empty;
    assign ovf_set     = (wr_data && fifo_full && !fifo_pop)
                       || ((wr_spi || wr_sel) && !engine_idle);
    assign half_end    = (div_cnt == '0);

    // Every path that lands in SHIFT next cycle, so cs_n falls ahead of the first half-bit.
    assign shift_next = (state == ST_IDLE   && spi_go)
                     || (state == ST_COLUMN  && cnt_px != 4'd0)
                     || (state == ST_SEL_CMD && half_end);
    assign cs_n = cs_reg && (state != ST_SHIFT) && !shift_next;

    assign glyph = column_bits(bfr[7], prev_bit, edge_en,
                               HI_GLYPH[6:0], LO_GLYPH[6:0], EDGE_GLYPH[6:0]);

    waveforms_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (data_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cont     <= ST_IDLE;
            presc    <= PRESC_W'(4);
            div_cnt  <= '0;
            half_cnt <= '0;
            cnt_px   <= '0;
            tx       <= '0;
            bfr      <= '0;
            sck      <= CPOL;
            mosi     <= 1'b0;
            dc       <= 1'b0;
            gnd      <= 1'b0;
            edge_en  <= 1'b0;
            cs_reg   <= 1'b1;
            overflow <= 1'b0;
            prev_bit <= 1'b0;
        end else begin
            if (ovf_set)  overflow <= 1'b1;
            if (wr_presc) presc    <= data_in[PRESC_W-1:0];
            if (wr_ctrl) begin
                cs_reg  <= data_in[CTRL_CS];
                dc      <= data_in[CTRL_DC];
                gnd     <= data_in[CTRL_GND];
                edge_en <= data_in[CTRL_EDGE];
                if (data_in[CTRL_CLR_OVF]) overflow <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    sck <= CPOL;
                    if (spi_go) begin
                        tx       <= data_in;
                        mosi     <= data_in[7];
                        div_cnt  <= presc;
                        half_cnt <= '0;
                        cont     <= ST_IDLE;
                        state    <= ST_SHIFT;
                    end else if (sel_go) begin
                        tx       <= SEL_OPCODE | {5'b0, data_in[2:0]};
                        dc       <= 1'b0;
                        prev_bit <= 1'b0;
                        div_cnt  <= presc;
                        state    <= ST_SEL_CMD;
                    end else if (!fifo_empty) begin
                        bfr    <= fifo_data;
                        cnt_px <= 4'd8;
                        state  <= ST_COLUMN;
                    end
                end

                ST_COLUMN: begin
                    if (cnt_px == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        tx       <= {gnd, glyph};
                        mosi     <= gnd;
                        prev_bit <= bfr[7];
                        bfr      <= {bfr[6:0], 1'b0};
                        cnt_px   <= cnt_px - 4'd1;
                        div_cnt  <= presc;
                        half_cnt <= '0;
                        cont     <= ST_COLUMN;
                        state    <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (half_end) begin
                        div_cnt  <= presc;
                        half_cnt <= half_cnt + 4'd1;
                        sck      <= ~sck;
                        // Odd half-bits end on the trailing edge: present the next bit.
                        if (half_cnt[0]) begin
                            tx   <= {tx[6:0], 1'b0};
                            mosi <= tx[6];
                        end
                        if (half_cnt == 4'd15) begin
                            sck   <= CPOL;
                            state <= cont;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end

                ST_SEL_CMD: begin
                    dc <= 1'b0;
                    if (half_end) begin
                        mosi     <= tx[7];
                        div_cnt  <= presc;
                        half_cnt <= '0;
                        cont     <= ST_DC_RESTORE;
                        state    <= ST_SHIFT;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end

                ST_DC_RESTORE: begin
                    dc    <= 1'b1;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign lvl_ext = 5'(fifo_level);
    assign lvl_sat = lvl_ext[4] ? 4'hF : lvl_ext[3:0];

    // NOTE: data_out gets a default before the case so no read path infers a latch.
    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_STATUS: data_out = {lvl_sat, overflow, fifo_empty, fifo_full, engine_idle};
            ADDR_PREV:   data_out = {7'b0, prev_bit};
            default:     data_out = 8'h00;
        endcase
    end

    assign uo_out = {3'b000, dc, cs_n, mosi, sck, 1'b0};

endmodule

// File: doc/tqvp_waveforms_streamer.md
Name: tqvp_waveforms_streamer

Overview:
SSD1306 waveform-plotter peripheral for the TinyQV peripheral bus. It is a parametrised successor to the single-byte plotter. The CPU pushes pixel bytes into an on-chip FIFO. The engine expands each bit into one OLED column glyph (high, low, or optional edge glyph) and shifts it out over SPI, so software can write ahead without polling after every byte. Raw SPI tunnelling and page-select commands are kept.

Parameters:
PRESC_W, 4, prescaler width in bits (1..8); half-bit length is presc+1 clk cycles.
FIFO_DEPTH, 4, pixel-byte FIFO entries; power of two, 2..16.
CPOL, 0, SCK idle level.
HI_GLYPH, 8'h02, column byte for a 1 bit (bit7 is replaced by gnd).
LO_GLYPH, 8'h40, column byte for a 0 bit (bit7 is replaced by gnd).
EDGE_GLYPH, 8'h7E, column byte for a transition column (bit7 is replaced by gnd).

Ports:
clk  in  1  clock, 64 MHz nominal
rst_n  in  1  reset
ui_in  in  8  unused
uo_out  out  8  [0]=0, [1]=sck, [2]=mosi, [3]=cs_n, [4]=dc, [7:5]=0
address  in  4  register address
data_write  in  1  write strobe, single cycle
data_in  in  8  write data
data_out  out  8  read data, combinational on address

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk.
- Reset values: sck=CPOL, mosi=0, cs_n=1, dc=0, presc=4, gnd=0, edge_en=0, cs_reg=1, FIFO empty, overflow=0, prev_bit=0, state=IDLE. A reset mid-transfer aborts immediately and discards the FIFO contents.
- Write map:
  - 0x0 DATA: push data_in into the FIFO. If the FIFO is full, drop the byte and set sticky overflow. A push and a pop in the same cycle on a full FIFO is accepted.
  - 0x1 SPI: send data_in raw. Accepted only when idle (FSM IDLE and FIFO empty); otherwise dropped and overflow set.
  - 0x2 PRESC: presc <= data_in[PRESC_W-1:0].
  - 0x3 CTRL: [0] cs_reg, [1] dc, [2] gnd, [3] edge_en, [4]=1 clears overflow (self-clearing).
  - 0x8 SEL: send 0xB0|data_in[2:0] with dc=0, then set dc=1. Clears prev_bit. Accepted only when idle; otherwise dropped and overflow set.
  - All other addresses: no effect.
  - PRESC and CTRL writes are always accepted. A new presc applies at the next half-bit reload. A dc change applies immediately; safe use is software's responsibility.
- Read map:
  - 0x0: {level[3:0] (saturates at 15), overflow, empty, full, idle}.
  - 0x1: {7'b0, prev_bit}.
  - All other addresses read 0.
- FSM states:
  - IDLE: priority is SPI write, then SEL write, then FIFO non-empty (pop into bfr, cnt_px=8, go to COLUMN).
  - COLUMN: if cnt_px==0, go to IDLE. Otherwise:
    - glyph = EDGE_GLYPH if edge_en and bfr[7]!=prev_bit; else HI_GLYPH if bfr[7]=1; else LO_GLYPH.
    - tx = {gnd, glyph[6:0]}; prev_bit <= bfr[7]; bfr <<= 1; cnt_px--; go to SHIFT with continuation COLUMN.
  - SHIFT: 16 half-bits, each presc+1 cycles, so one byte takes exactly 16*(presc+1) cycles.
    - sck toggles at the end of each half-bit. MSB first.
    - mosi updates after each trailing (second) edge.
    - On the last half-bit, go to the continuation state and return sck to CPOL.
  - SEL_CMD: dc=0, load tx, wait one prescaler period, then SHIFT with continuation DC_RESTORE.
  - DC_RESTORE: dc=1, go to IDLE.
- Per-byte overhead: one COLUMN cycle between consecutive columns. One pop cycle between FIFO bytes (IDLE→COLUMN).
- cs_n = cs_reg & (state!=SHIFT) & (next_state!=SHIFT). cs_n therefore drops no later than the cycle the first sck half-bit begins, and rises one cycle after the last.
- sck is forced to CPOL whenever the state is IDLE.

Decomposition:
- Package waveforms_pkg: state enum (IDLE, COLUMN, SHIFT, SEL_CMD, DC_RESTORE), register address constants, status bit indices, default glyph constants, SEL opcode 0xB0.
- Sub-module waveforms_fifo: synchronous FIFO with parameter DEPTH, 8-bit data, push/pop/full/empty/level outputs, and first-word-fall-through read.

Test Plan:
- Reset, then read 0x0 → 0x05 (idle=1, empty=1); uo_out[4:1]=4'b0100 (dc=0, cs_n=1, mosi=0, sck=0).
- PRESC=1, SPI 0xA5 → cs_n low for 32 cycles; mosi samples on rising sck = 1,0,1,0,0,1,0,1; 8 sck pulses each 2 cycles high/2 low; idle returns.
- PRESC=0, SEL 3 → byte 0xB3 shifted with dc=0; dc=1 one cycle after shift ends; read 0x1 → 0.
- edge_en=0, gnd=0, DATA 0xA0 → columns 02,40,02,40,40,40,40,40; gnd=1 → the same columns with bit7 set (82,C0,...).
- edge_en=1, prev_bit=0, DATA 0xA0 → columns 7E,7E,7E,7E,40,40,40,40; read 0x1 → 0.
- PRESC=15, DATA ×1, then after the pop, DATA ×5 back-to-back → 4 stored, full=1, overflow=1. CTRL bit4 → overflow=0. All 5 accepted bytes are emitted as 40 columns, then idle=1.
